// File: rtl/jbu_pkg.sv
// Shared opcodes, counter encodings and counter-step helper for the branch predictor.
package jbu_pkg;

  localparam int unsigned OP_WIDTH  = 4;
  localparam int unsigned CTR_WIDTH = 2;

  localparam logic [OP_WIDTH-1:0] OP_BLT  = 4'b0100;
  localparam logic [OP_WIDTH-1:0] OP_BGT  = 4'b0101;
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = 4'b0110;
  localparam logic [OP_WIDTH-1:0] OP_BNE  = 4'b0111;
  localparam logic [OP_WIDTH-1:0] OP_JUMP = 4'b1100;

  typedef enum logic [CTR_WIDTH-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  // Saturating step of a 2-bit counter toward the resolved outcome.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = CTR_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational opcode + flag evaluation: control/conditional class and outcome.
module branch_cond_eval
  import jbu_pkg::*;
#(
  parameter int unsigned OPSIZE = 4
) (
  input  logic [OPSIZE-1:0] op,
  input  logic              zero,
  input  logic              sign,
  output logic              is_ctrl_c,
  output logic              is_cond_c,
  output logic              taken_c
);

  // Classify the opcode and evaluate its condition against the supplied flags.
  always_comb begin
    is_ctrl_c = 1'b0;
    is_cond_c = 1'b0;
    taken_c   = 1'b0;
    case (op)
      OPSIZE'(OP_BLT): begin
        is_ctrl_c = 1'b1;
        is_cond_c = 1'b1;
        taken_c   = sign & ~zero;
      end
      OPSIZE'(OP_BGT): begin
        is_ctrl_c = 1'b1;
        is_cond_c = 1'b1;
        taken_c   = ~sign & ~zero;
      end
      OPSIZE'(OP_BEQ): begin
        is_ctrl_c = 1'b1;
        is_cond_c = 1'b1;
        taken_c   = zero;
      end
      OPSIZE'(OP_BNE): begin
        is_ctrl_c = 1'b1;
        is_cond_c = 1'b1;
        taken_c   = ~zero;
      end
      OPSIZE'(OP_JUMP): begin
        is_ctrl_c = 1'b1;
        taken_c   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: 2-bit counter table for decode prediction, execute-stage resolution.
module branch_predict_unit
  import jbu_pkg::*;
#(
  parameter int unsigned OPSIZE    = 4,
  parameter int unsigned PC_WIDTH  = 8,
  parameter int unsigned IDX_BITS  = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flag_we,
  input  logic                 zero_in,
  input  logic                 sign_in,
  input  logic [OPSIZE-1:0]    dec_op_code,
  input  logic [PC_WIDTH-1:0]  dec_pc,
  output logic                 predict_taken,
  input  logic                 ex_valid,
  input  logic [OPSIZE-1:0]    ex_op_code,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic                 ex_pred_taken,
  output logic                 resolve_valid,
  output logic                 jump_branch_flag,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;

  ctr_t                table_q [DEPTH];
  logic                zero_q;
  logic                sign_q;
  logic                zero_eff;
  logic                sign_eff;
  logic [IDX_BITS-1:0] dec_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                dec_is_cond;
  logic                ex_is_ctrl;
  logic                ex_is_cond;
  logic                ex_taken;
  logic                resolve;
  logic                unused_pc_bits;

  assign dec_idx        = dec_pc[IDX_BITS-1:0];
  assign ex_idx         = ex_pc[IDX_BITS-1:0];
  assign unused_pc_bits = ^{dec_pc, ex_pc};

  // Freshly written flags bypass the register for a same-cycle resolution.
  assign zero_eff = flag_we ? zero_in : zero_q;
  assign sign_eff = flag_we ? sign_in : sign_q;

  branch_cond_eval #(.OPSIZE(OPSIZE)) u_ex_eval (
    .op        (ex_op_code),
    .zero      (zero_eff),
    .sign      (sign_eff),
    .is_ctrl_c (ex_is_ctrl),
    .is_cond_c (ex_is_cond),
    .taken_c   (ex_taken)
  );

  assign resolve = ex_valid & ex_is_ctrl;

  // Decode-side prediction reads the pre-update table state.
  always_comb begin
    dec_is_cond   = (dec_op_code == OPSIZE'(OP_BLT)) || (dec_op_code == OPSIZE'(OP_BGT)) ||
                    (dec_op_code == OPSIZE'(OP_BEQ)) || (dec_op_code == OPSIZE'(OP_BNE));
    predict_taken = 1'b0;
    if (dec_op_code == OPSIZE'(OP_JUMP)) begin
      predict_taken = 1'b1;
    end else if (dec_is_cond) begin
      predict_taken = table_q[dec_idx][1];
    end
  end

  // ALU flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      sign_q <= 1'b0;
    end else if (flag_we) begin
      zero_q <= zero_in;
      sign_q <= sign_in;
    end
  end

  // Registered resolution pulses and saturating mispredict count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolve_valid    <= 1'b0;
      jump_branch_flag <= 1'b0;
      mispredict       <= 1'b0;
      mispredict_count <= '0;
    end else begin
      resolve_valid    <= resolve;
      jump_branch_flag <= resolve & ex_taken;
      mispredict       <= resolve & (ex_taken != ex_pred_taken);
      if (resolve && (ex_taken != ex_pred_taken) && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      end
    end
  end

  // Counter table trains only on resolved conditional branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[IDX_BITS'(i)] <= CTR_RESET;
      end
    end else if (resolve && ex_is_cond) begin
      table_q[ex_idx] <= ctr_next(table_q[ex_idx], ex_taken);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: vector table, directed corners, random vs model.
module tb_branch_predict_unit;

  localparam logic [3:0] BLT  = 4'b0100;
  localparam logic [3:0] BGT  = 4'b0101;
  localparam logic [3:0] BEQ  = 4'b0110;
  localparam logic [3:0] BNE  = 4'b0111;
  localparam logic [3:0] JUMP = 4'b1100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flag_we;
  logic       zero_in;
  logic       sign_in;
  logic [3:0] dec_op_code;
  logic [7:0] dec_pc;
  logic       predict_taken;
  logic       ex_valid;
  logic [3:0] ex_op_code;
  logic [7:0] ex_pc;
  logic       ex_pred_taken;
  logic       resolve_valid;
  logic       jump_branch_flag;
  logic       mispredict;
  logic [7:0] mispredict_count;

  branch_predict_unit #(
    .OPSIZE(4), .PC_WIDTH(8), .IDX_BITS(4), .CNT_WIDTH(8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flag_we          (flag_we),
    .zero_in          (zero_in),
    .sign_in          (sign_in),
    .dec_op_code      (dec_op_code),
    .dec_pc           (dec_pc),
    .predict_taken    (predict_taken),
    .ex_valid         (ex_valid),
    .ex_op_code       (ex_op_code),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .resolve_valid    (resolve_valid),
    .jump_branch_flag (jump_branch_flag),
    .mispredict       (mispredict),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: counters as plain integers 0..3, flags, mispredict total.
  int m_ctr [16];
  bit m_z;
  bit m_s;
  int m_cnt;

  typedef struct {
    logic [3:0] op;
    logic [7:0] pc;
    logic       exp_pred;
  } dec_vec_t;

  dec_vec_t vecs [6];

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_z   = 1'b0;
    m_s   = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic bit m_is_cond(input logic [3:0] op);
    return (op == BLT) || (op == BGT) || (op == BEQ) || (op == BNE);
  endfunction

  function automatic bit m_taken(input logic [3:0] op, input bit z, input bit s);
    if (op == BLT) return s && !z;
    if (op == BGT) return !s && !z;
    if (op == BEQ) return z;
    if (op == BNE) return !z;
    return op == JUMP;
  endfunction

  // One clock of stimulus: check the live prediction, advance the model, check registered outputs.
  task automatic run_cycle(input string tag);
    bit exp_pred, z, s, res, tk, exp_mis;
    int idx;
    if (dec_op_code == JUMP) exp_pred = 1'b1;
    else if (m_is_cond(dec_op_code)) exp_pred = (m_ctr[dec_pc % 16] >= 2);
    else exp_pred = 1'b0;
    #1;
    check({tag, ".predict"}, predict_taken, exp_pred);
    z   = flag_we ? zero_in : m_z;
    s   = flag_we ? sign_in : m_s;
    res = ex_valid && (m_is_cond(ex_op_code) || ex_op_code == JUMP);
    tk  = m_taken(ex_op_code, z, s);
    exp_mis = res && (tk != ex_pred_taken);
    if (exp_mis && m_cnt < 255) m_cnt++;
    idx = ex_pc % 16;
    if (res && m_is_cond(ex_op_code)) begin
      if (tk) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
      else    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
    end
    if (flag_we) begin
      m_z = zero_in;
      m_s = sign_in;
    end
    @(posedge clk);
    #1;
    check({tag, ".resolve_valid"}, resolve_valid, res);
    check({tag, ".jbf"}, jump_branch_flag, res && tk);
    check({tag, ".mispredict"}, mispredict, exp_mis);
    check({tag, ".count"}, mispredict_count, m_cnt);
  endtask

  task automatic set_ex(input bit v, input logic [3:0] op, input logic [7:0] pc, input bit pt);
    ex_valid      = v;
    ex_op_code    = op;
    ex_pc         = pc;
    ex_pred_taken = pt;
  endtask

  task automatic set_flags(input bit we, input bit z, input bit s);
    flag_we = we;
    zero_in = z;
    sign_in = s;
  endtask

  logic [3:0] rand_ops [8];

  initial begin
    vecs[0] = '{op: BEQ,   pc: 8'h00, exp_pred: 1'b0};
    vecs[1] = '{op: JUMP,  pc: 8'h3c, exp_pred: 1'b1};
    vecs[2] = '{op: 4'h0,  pc: 8'h05, exp_pred: 1'b0};
    vecs[3] = '{op: BLT,   pc: 8'h11, exp_pred: 1'b0};
    vecs[4] = '{op: BNE,   pc: 8'hff, exp_pred: 1'b0};
    vecs[5] = '{op: 4'hd,  pc: 8'h07, exp_pred: 1'b0};
    rand_ops = '{BLT, BGT, BEQ, BNE, JUMP, 4'h0, 4'h3, 4'hf};

    rst_n = 1'b0;
    set_flags(0, 0, 0);
    set_ex(0, 4'h0, 8'h00, 0);
    dec_op_code = 4'h0;
    dec_pc      = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.resolve_valid", resolve_valid, 0);
    check("reset.jbf", jump_branch_flag, 0);
    check("reset.mispredict", mispredict, 0);
    check("reset.count", mispredict_count, 0);
    rst_n = 1'b1;

    // Decode predictions straight out of reset.
    for (int i = 0; i < 6; i++) begin
      dec_op_code = vecs[i].op;
      dec_pc      = vecs[i].pc;
      #1;
      check($sformatf("vec%0d.predict", i), predict_taken, vecs[i].exp_pred);
    end
    @(posedge clk);
    #1;

    // Load Z=1,S=0 then resolve two mispredicted BEQs at index 3.
    dec_op_code = 4'h0;
    set_flags(1, 1, 0);
    run_cycle("flags_load");
    set_flags(0, 0, 0);
    set_ex(1, BEQ, 8'h03, 0);
    run_cycle("beq1");
    check("beq1.jbf_const", jump_branch_flag, 1);
    check("beq1.count_const", mispredict_count, 1);
    run_cycle("beq2");
    set_ex(0, 4'h0, 8'h00, 0);
    dec_op_code = BEQ;
    dec_pc      = 8'h13;
    run_cycle("beq_pred13");
    check("pred13_const", predict_taken, 1);

    // Flag bypass: register holds Z=1, new flags Z=0,S=1 written alongside BLT.
    dec_op_code = 4'h0;
    set_flags(1, 0, 1);
    set_ex(1, BLT, 8'h00, 0);
    run_cycle("bypass");
    check("bypass.jbf_const", jump_branch_flag, 1);
    set_flags(0, 0, 0);

    // Same-cycle decode/execute on index 5: prediction reads the old counter.
    dec_op_code = BEQ;
    dec_pc      = 8'h25;
    set_ex(1, BLT, 8'h05, 0);
    run_cycle("rbw_same");
    set_ex(0, 4'h0, 8'h00, 0);
    run_cycle("rbw_next");
    check("rbw_next.pred_const", predict_taken, 1);

    // Four not-taken BEQs at index 7 pin the counter at 00; two takens then flip it.
    dec_op_code = BEQ;
    dec_pc      = 8'h07;
    for (int i = 0; i < 4; i++) begin
      set_ex(1, BEQ, 8'h07, 0);
      run_cycle($sformatf("nt%0d", i));
    end
    set_flags(1, 1, 0);
    set_ex(1, BEQ, 8'h17, 1);
    run_cycle("nt_up1");
    set_flags(0, 0, 0);
    set_ex(0, 4'h0, 8'h00, 0);
    run_cycle("nt_after1");
    check("sat00.pred_const", predict_taken, 0);
    set_ex(1, BEQ, 8'h07, 1);
    run_cycle("nt_up2");
    set_ex(0, 4'h0, 8'h00, 0);
    run_cycle("nt_after2");

    // Reset in the middle of a resolving BEQ discards it and clears state.
    set_ex(1, BEQ, 8'h03, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.resolve_valid", resolve_valid, 0);
    check("midrst.count", mispredict_count, 0);
    @(posedge clk);
    #1;
    check("midrst.resolve_after_edge", resolve_valid, 0);
    set_ex(0, 4'h0, 8'h00, 0);
    dec_op_code = BEQ;
    dec_pc      = 8'h03;
    #1;
    check("midrst.pred3", predict_taken, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      dec_op_code = rand_ops[$urandom_range(0, 7)];
      dec_pc      = 8'($urandom_range(0, 255));
      set_flags(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_ex(1'($urandom_range(0, 3) != 0), rand_ops[$urandom_range(0, 7)],
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      run_cycle("rand");
    end

    // Mispredict count saturation at all-ones.
    set_flags(0, 0, 0);
    dec_op_code = 4'h0;
    for (int i = 0; i < 259; i++) begin
      set_ex(1, JUMP, 8'($urandom_range(0, 255)), 0);
      run_cycle("cntsat");
    end
    check("cntsat.count_const", mispredict_count, 255);
    set_ex(0, 4'h0, 8'h00, 0);
    run_cycle("cntsat_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
